brick_hit_detector: RTL and testbench

Collision front end for the brick field. It sits upstream of the brick-map block and is the sole producer of its break request: break row, break column and a one-cycle `Brick_Broke` strobe. Each `frame_clk` it compares the ball's bounding box against the current brick-present map. It issues at most one break per hit, followed by a cooldown, and also produces bounce pulses, a score and a bricks-remaining count.

---
 rtl/brick_hit_detector.sv | 170 +++++++++++++++++
 tb/tb_brick_hit_detector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/brick_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : brick_hit_detector
// Brief    : Ball/brick collision front end. Issues one break request per hit
//            and then a cooldown. It also produces bounce pulses, the score and
//            the bricks-left count. The score accumulator exists only when
//            BRICK_HIT_SCORE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module brick_hit_detector #(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int GRID_X0  = 64,
  parameter int GRID_Y0  = 40,
  parameter int BRICK_W  = 64,
  parameter int BRICK_H  = 20,
  parameter int COOLDOWN = 4,
  parameter int POINTS   = 10
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   Restart,
  input  logic [9:0]             BallX,
  input  logic [9:0]             BallY,
  input  logic [9:0]             BallS,
  input  logic [ROWS*COLS-1:0]   BrickMap,
  output logic [7:0]             BreakRow,
  output logic [7:0]             BreakCol,
  output logic                   Brick_Broke,
  output logic                   BounceX,
  output logic                   BounceY,
  output logic [15:0]            Score,
  output logic [7:0]             BricksLeft,
  output logic                   LevelClear
);

  localparam int          c_N     = ROWS * COLS;
  localparam int          c_IW    = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [10:0] c_X0    = 11'(GRID_X0);
  localparam logic [10:0] c_Y0    = 11'(GRID_Y0);
  localparam logic [10:0] c_BW    = 11'(BRICK_W);
  localparam logic [10:0] c_BH    = 11'(BRICK_H);
  localparam logic [7:0]  c_TOTAL = 8'(c_N);
  localparam logic [15:0] c_CNT0  = 16'(COOLDOWN - 1);
  localparam logic [16:0] c_POINTS = 17'(POINTS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIT = 2'd1, S_COOL = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [7:0]  r_row, r_col, r_left;
  logic        r_bx, r_by, r_clear;

  logic [10:0] w_l, w_t, w_r, w_b;
  logic [10:0] w_cx [4];
  logic [10:0] w_cy [4];
  logic [10:0] w_row [4];
  logic [10:0] w_col [4];
  logic [3:0]  w_hit;
  logic        w_found, w_take, w_in_span;
  logic [10:0] w_sel_row, w_sel_col;
  logic [15:0] w_span_lo, w_span_hi;

  assign w_l = (BallX < BallS) ? 11'd0 : {1'b0, BallX - BallS};
  assign w_t = (BallY < BallS) ? 11'd0 : {1'b0, BallY - BallS};
  assign w_r = {1'b0, BallX} + {1'b0, BallS};
  assign w_b = {1'b0, BallY} + {1'b0, BallS};

  // Corner index bit 0 selects right edge, bit 1 selects bottom edge: TL, TR, BL, BR.
  for (genvar gi = 0; gi < 4; gi++) begin : g_corner
    logic [c_IW-1:0] w_idx;
    assign w_cx[gi]  = (gi % 2 == 1) ? w_r : w_l;
    assign w_cy[gi]  = (gi >= 2) ? w_b : w_t;
    assign w_col[gi] = (w_cx[gi] - c_X0) / c_BW;
    assign w_row[gi] = (w_cy[gi] - c_Y0) / c_BH;
    assign w_idx     = c_IW'(w_row[gi] * 11'(COLS) + w_col[gi]);
    assign w_hit[gi] = (w_cx[gi] >= c_X0) && (w_cy[gi] >= c_Y0) &&
                       (w_col[gi] < 11'(COLS)) && (w_row[gi] < 11'(ROWS)) &&
                       BrickMap[w_idx];
  end

  always_comb begin
    w_found   = 1'b0;
    w_sel_row = '0;
    w_sel_col = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_found   = 1'b1;
        w_sel_row = w_row[i];
        w_sel_col = w_col[i];
      end
    end
  end

  assign w_span_lo = 16'(GRID_X0) + 16'(w_sel_col) * 16'(BRICK_W);
  assign w_span_hi = w_span_lo + 16'(BRICK_W - 1);
  assign w_in_span = (16'(BallX) >= w_span_lo) && (16'(BallX) <= w_span_hi);
  assign w_take    = (r_state == S_IDLE) && w_found && !r_clear;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)        r_state <= S_IDLE;
    else if (Restart) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // Counter runs COOLDOWN-1..1 in COOL; the IDLE sampling cycle completes the spacing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_HIT;
      S_HIT:   w_next = S_COOL;
      S_COOL:  if (r_cnt <= 16'd1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0; r_row <= '0; r_col <= '0;
      r_bx  <= 1'b0; r_by <= 1'b0;
      r_left <= c_TOTAL; r_clear <= 1'b0;
    end else if (Restart) begin
      r_cnt <= '0; r_row <= '0; r_col <= '0;
      r_bx  <= 1'b0; r_by <= 1'b0;
      r_left <= c_TOTAL; r_clear <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_row   <= 8'(w_sel_row);
            r_col   <= 8'(w_sel_col);
            r_by    <= w_in_span;
            r_bx    <= !w_in_span;
            r_left  <= (r_left != 8'd0) ? r_left - 8'd1 : 8'd0;
            r_clear <= (r_left <= 8'd1);
          end
        end
        S_HIT:   r_cnt <= c_CNT0;
        S_COOL:  r_cnt <= r_cnt - 16'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

`ifdef BRICK_HIT_SCORE_EN
  logic [15:0] r_score;
  logic [16:0] w_score_sum;
  assign w_score_sum = {1'b0, r_score} + c_POINTS;
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)        r_score <= '0;
    else if (Restart) r_score <= '0;
    else if (w_take)  r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
  end
  assign Score = r_score;
`else
  logic w_unused_points;
  assign w_unused_points = ^c_POINTS;
  assign Score = '0;
`endif

  assign Brick_Broke = (r_state == S_HIT);
  assign BounceX     = Brick_Broke & r_bx;
  assign BounceY     = Brick_Broke & r_by;
  assign BreakRow    = r_row;
  assign BreakCol    = r_col;
  assign BricksLeft  = r_left;
  assign LevelClear  = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_brick_hit_detector.sv
`default_nettype none
// Bench for brick_hit_detector: directed scenarios then random balls/maps,
// all compared with a frame-timeline reference model.
module tb_brick_hit_detector;

`ifdef BRICK_HIT_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic        frame_clk, Reset, Restart;
  logic [9:0]  BallX, BallY, BallS;
  logic [31:0] BrickMap;
  logic [7:0]  BreakRow, BreakCol, BricksLeft;
  logic        Brick_Broke, BounceX, BounceY, LevelClear;
  logic [15:0] Score;

  brick_hit_detector dut (
    .frame_clk(frame_clk), .Reset(Reset), .Restart(Restart),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .BrickMap(BrickMap),
    .BreakRow(BreakRow), .BreakCol(BreakCol), .Brick_Broke(Brick_Broke),
    .BounceX(BounceX), .BounceY(BounceY), .Score(Score),
    .BricksLeft(BricksLeft), .LevelClear(LevelClear)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_run = 0, n_fail = 0;
  int edge_n = 0, m_ready = 0, pend_clear = -1;
  int m_score = 0, m_left = 32, m_row = 0, m_col = 0;
  bit m_clear = 0, m_strobe = 0, m_by = 0, auto_clear = 1;
  int obs_strobes = 0, last_edge = 0, last_gap = 0;
  logic [9:0]  g_bx = 0, g_by = 0, g_bs = 0;
  logic        g_restart = 0;
  logic [31:0] g_map = '1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Spec-level collision rule: first in-grid corner (TL,TR,BL,BR) over a present brick.
  function automatic void find_hit(input int x, input int y, input int s, input logic [31:0] mp,
                                   output bit f, output int row, output int col, output bit bnc_y);
    int xs[4]; int ys[4]; int l, t;
    l = (x < s) ? 0 : x - s;
    t = (y < s) ? 0 : y - s;
    xs[0] = l; xs[1] = x + s; xs[2] = l;     xs[3] = x + s;
    ys[0] = t; ys[1] = t;     ys[2] = y + s; ys[3] = y + s;
    f = 0; row = 0; col = 0;
    for (int i = 0; i < 4; i++) begin
      if (!f && xs[i] >= 64 && ys[i] >= 40) begin
        int cc, rr;
        cc = (xs[i] - 64) / 64;
        rr = (ys[i] - 40) / 20;
        if (cc < 8 && rr < 4 && mp[rr*8+cc]) begin f = 1; row = rr; col = cc; end
      end
    end
    bnc_y = f && (x >= 64 + col*64) && (x <= 64 + col*64 + 63);
  endfunction

  task automatic model_reset();
    m_score = 0; m_left = 32; m_clear = 0; m_row = 0; m_col = 0;
    m_strobe = 0; m_by = 0; pend_clear = -1;
  endtask

  // One frame: drive at negedge, model the edge, check at the following negedge.
  task automatic cycle();
    bit f, byv; int r, c;
    if (pend_clear >= 0 && auto_clear) g_map[pend_clear] = 1'b0;
    pend_clear = -1;
    BallX = g_bx; BallY = g_by; BallS = g_bs; BrickMap = g_map; Restart = g_restart;
    @(posedge frame_clk);
    edge_n++;
    m_strobe = 0;
    if (g_restart) begin
      model_reset();
      m_ready = edge_n + 1;
    end else if (edge_n >= m_ready && !m_clear) begin
      find_hit(int'(g_bx), int'(g_by), int'(g_bs), g_map, f, r, c, byv);
      if (f) begin
        m_strobe = 1; m_row = r; m_col = c; m_by = byv;
        if (SCORE_ON) m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        if (m_left > 0) m_left--;
        m_clear = (m_left == 0);
        m_ready = edge_n + 5;
        pend_clear = r*8 + c;
      end
    end
    @(negedge frame_clk);
    if (Brick_Broke === 1'b1) begin
      obs_strobes++; last_gap = edge_n - last_edge; last_edge = edge_n;
    end
    chk("strobe", Brick_Broke, m_strobe);
    chk("bounce_x", BounceX, m_strobe && !m_by);
    chk("bounce_y", BounceY, m_strobe && m_by);
    chk("break_row", BreakRow, m_row);
    chk("break_col", BreakCol, m_col);
    chk("score", Score, m_score);
    chk("left", BricksLeft, m_left);
    chk("clear", LevelClear, m_clear);
  endtask

  task automatic ball(input int x, input int y, input int s);
    g_bx = 10'(x); g_by = 10'(y); g_bs = 10'(s);
  endtask

  task automatic idle_out(input int n);
    ball(30, 10, 4);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    Reset = 1'b1; Restart = 1'b0; BallX = 0; BallY = 0; BallS = 0; BrickMap = '1;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
    chk("rst_strobe", Brick_Broke, 0);
    chk("rst_bounce", {BounceX, BounceY}, 0);
    chk("rst_rowcol", {BreakRow, BreakCol}, 0);
    chk("rst_score", Score, 0);
    chk("rst_left", BricksLeft, 32);
    chk("rst_clear", LevelClear, 0);

    // First hit, ball centred over brick (0,0)
    ball(100, 50, 4); cycle();
    chk("t1_row", BreakRow, 0); chk("t1_col", BreakCol, 0);
    chk("t1_strobe", Brick_Broke, 1); chk("t1_by", BounceY, 1);
    chk("t1_score", Score, SCORE_ON ? 10 : 0); chk("t1_left", BricksLeft, 31);
    idle_out(6);

    // Side hit: TL corner in row 1 col 0, centre outside column span
    ball(128, 70, 4); cycle();
    chk("t2_row", BreakRow, 1); chk("t2_col", BreakCol, 0);
    chk("t2_bx", BounceX, 1); chk("t2_by", BounceY, 0);
    idle_out(6);

    // Held ball, bit cleared after strobe: exactly one break
    obs_strobes = 0; auto_clear = 1;
    ball(200, 90, 4);
    for (int i = 0; i < 12; i++) cycle();
    chk("held_once", obs_strobes, 1);
    idle_out(6);

    // Held ball, bit never cleared: strobes every 5 frames
    obs_strobes = 0; auto_clear = 0;
    ball(300, 110, 4);
    for (int i = 0; i < 11; i++) cycle();
    chk("held_repeat", obs_strobes, 3);
    chk("held_gap", last_gap, 5);
    auto_clear = 1;
    idle_out(6);

    // Out-of-grid balls
    obs_strobes = 0;
    idle_out(6);
    ball(600, 200, 4);
    for (int i = 0; i < 6; i++) cycle();
    chk("outgrid", obs_strobes, 0);

    // Drain the field to one brick, then clear the level
    g_restart = 1; cycle(); g_restart = 0;
    g_map = '1;
    for (int k = 1; k < 32; k++) begin
      ball(96 + (k % 8) * 64, 50 + (k / 8) * 20, 2);
      cycle();
      idle_out(5);
    end
    chk("drain_left", BricksLeft, 1);
    g_map = 32'h1;
    ball(100, 50, 4); cycle();
    chk("lc_clear", LevelClear, 1); chk("lc_left", BricksLeft, 0);
    idle_out(5);
    obs_strobes = 0; g_map = '1;
    ball(200, 90, 4);
    for (int i = 0; i < 8; i++) cycle();
    chk("lc_nohit", obs_strobes, 0);
    g_restart = 1; cycle(); g_restart = 0;
    chk("rs_clear", LevelClear, 0); chk("rs_left", BricksLeft, 32); chk("rs_score", Score, 0);

    // Asynchronous reset while in HIT
    idle_out(2);
    ball(100, 50, 4); cycle();
    chk("pre_rst_strobe", Brick_Broke, 1);
    Reset = 1'b1;
    #1;
    chk("rst_hit_strobe", Brick_Broke, 0);
    chk("rst_hit_score", Score, 0);
    chk("rst_hit_left", BricksLeft, 32);
    model_reset(); m_ready = 0;
    @(negedge frame_clk);
    Reset = 1'b0;

    // Randomised play
    g_map = '1;
    for (int i = 0; i < 500; i++) begin
      g_restart = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) g_map = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      if ($urandom_range(0, 49) == 0) auto_clear = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)
        ball($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      else
        ball($urandom_range(0, 700), $urandom_range(0, 180), $urandom_range(0, 20));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
